// File: rtl/button_debouncer.sv
// Push-button conditioner: multi-flop synchronizer followed by a debounce FSM
// that only changes btn_clean after DEBOUNCE_CYCLES consecutive stable samples.
//
// state | meaning
// ------+------------------------------------------------------
// LOW   | stable released level, btn_clean=0
// L2H   | qualifying a press, btn_clean=0, busy=1
// HIGH  | stable pressed level, btn_clean=1
// H2L   | qualifying a release, btn_clean=1, busy=1
module button_debouncer #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic btn_clean,
   output logic busy
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   // Encoding chosen so bit1 is the clean level and bit0 is busy.
   localparam logic [1:0] ST_LOW  = 2'b00;
   localparam logic [1:0] ST_L2H  = 2'b01;
   localparam logic [1:0] ST_HIGH = 2'b10;
   localparam logic [1:0] ST_H2L  = 2'b11;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   btn_sync;
   logic [1:0]             state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
      end
   end

   assign btn_sync = sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_LOW: begin
            if (btn_sync) begin
               state_d = ST_L2H;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = '0;
            end
         end
         ST_L2H: begin
            if (!btn_sync) begin
               state_d = ST_LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_HIGH;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         ST_HIGH: begin
            if (!btn_sync) begin
               state_d = ST_H2L;
               cnt_d   = CNT_ONE;
            end
         end
         ST_H2L: begin
            if (btn_sync) begin
               state_d = ST_HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_LOW;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = ST_LOW;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_LOW;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign btn_clean = (state_q == ST_HIGH) || (state_q == ST_H2L);
   assign busy      = (state_q == ST_L2H)  || (state_q == ST_H2L);

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: a run-length reference model feeds a
// scoreboard queue that is checked one cycle at a time against the DUT.
module tb_button_debouncer;

   localparam int SYNC_STAGES     = 2;
   localparam int DEBOUNCE_CYCLES = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn_raw = 1'b0;
   logic btn_clean;
   logic busy;

   int n_checks = 0;
   int n_pass   = 0;

   logic [SYNC_STAGES-1:0] m_hist = '0;
   logic                   m_clean = 1'b0;
   int                     m_run = 0;
   logic [1:0]             sb_q[$];

   logic prev_clean = 1'b0;
   int   pulses = 0;

   button_debouncer #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_raw  (btn_raw),
      .btn_clean(btn_clean),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // Stand-in for the downstream rising-edge detector.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_clean <= 1'b0;
      end else begin
         if (btn_clean && !prev_clean) pulses <= pulses + 1;
         prev_clean <= btn_clean;
      end
   end

   task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed clean/busy=%b required=%b", tag, obs, exp);
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d required=%0d", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_hist  = '0;
      m_clean = 1'b0;
      m_run   = 0;
   endtask

   // Independent formulation: count consecutive synchronized samples that
   // disagree with the clean level; flip once the run reaches DEBOUNCE_CYCLES.
   task automatic model_edge(input logic raw);
      logic s;
      s = m_hist[SYNC_STAGES-1];
      if (s != m_clean) begin
         m_run++;
         if (m_run == DEBOUNCE_CYCLES) begin
            m_clean = s;
            m_run   = 0;
         end
      end else begin
         m_run = 0;
      end
      m_hist = {m_hist[SYNC_STAGES-2:0], raw};
   endtask

   task automatic step(input logic raw, input string tag);
      logic [1:0] exp;
      btn_raw = raw;
      @(posedge clk);
      model_edge(raw);
      sb_q.push_back({m_clean, (m_run != 0)});
      #1;
      exp = sb_q.pop_front();
      check(tag, {btn_clean, busy}, exp);
   endtask

   task automatic hold(input logic raw, input int n, input string tag);
      for (int i = 0; i < n; i++) step(raw, tag);
   endtask

   int p0;

   initial begin
      // 1: reset held with button pressed
      btn_raw = 1'b1;
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("reset_hold", {btn_clean, busy}, 2'b00);
      end
      #3;
      rst = 1'b0;
      model_reset();
      hold(1'b1, 5, "post_reset");
      check_int("post_reset_lat5", int'(btn_clean), 0);
      step(1'b1, "post_reset");
      check_int("post_reset_lat6", int'(btn_clean), 1);
      hold(1'b1, 3, "post_reset_hold");

      // 5: release from HIGH, no detector pulse expected
      p0 = pulses;
      hold(1'b0, 5, "release");
      check_int("release_lat5", int'(btn_clean), 1);
      step(1'b0, "release");
      check_int("release_lat6", int'(btn_clean), 0);
      hold(1'b0, 3, "release_idle");
      check_int("release_pulses", pulses - p0, 0);

      // 2: clean press, busy after edges 3..5
      p0 = pulses;
      step(1'b1, "press");
      step(1'b1, "press");
      check_int("press_busy_e2", int'(busy), 0);
      step(1'b1, "press");
      check_int("press_busy_e3", int'(busy), 1);
      step(1'b1, "press");
      step(1'b1, "press");
      check_int("press_busy_e5", int'(busy), 1);
      step(1'b1, "press");
      check_int("press_clean_e6", int'(btn_clean), 1);
      hold(1'b1, 4, "press_hold");
      check_int("press_pulses", pulses - p0, 1);

      // 4b: 3-cycle low glitch from HIGH
      hold(1'b0, 3, "glitch_low");
      hold(1'b1, 8, "glitch_low_after");
      check_int("glitch_low_clean", int'(btn_clean), 1);

      hold(1'b0, 10, "release2");

      // 4a: 3-cycle high glitch from LOW
      p0 = pulses;
      hold(1'b1, 3, "glitch_high");
      hold(1'b0, 8, "glitch_high_after");
      check_int("glitch_high_pulses", pulses - p0, 0);

      // 3: bounce then hold
      p0 = pulses;
      step(1'b1, "bounce");
      step(1'b0, "bounce");
      step(1'b1, "bounce");
      step(1'b1, "bounce");
      step(1'b0, "bounce");
      step(1'b1, "bounce");
      hold(1'b1, 4, "bounce_hold");
      check_int("bounce_lat5", int'(btn_clean), 0);
      step(1'b1, "bounce_hold");
      check_int("bounce_lat6", int'(btn_clean), 1);
      hold(1'b1, 4, "bounce_hold");
      check_int("bounce_pulses", pulses - p0, 1);

      // Reversal on the final counting sample aborts the release.
      hold(1'b0, 3, "late_reverse");
      hold(1'b1, 8, "late_reverse_after");
      check_int("late_reverse_clean", int'(btn_clean), 1);

      hold(1'b0, 10, "release3");

      // 6: reset while in L2H with cnt=2
      hold(1'b1, 4, "midcount");
      check_int("midcount_busy", int'(busy), 1);
      #2;
      rst = 1'b1;
      #1;
      check("midcount_reset", {btn_clean, busy}, 2'b00);
      model_reset();
      @(posedge clk);
      #1;
      check("midcount_reset_hold", {btn_clean, busy}, 2'b00);
      #3;
      rst = 1'b0;
      hold(1'b1, 5, "after_midreset");
      check_int("after_midreset_lat5", int'(btn_clean), 0);
      step(1'b1, "after_midreset");
      check_int("after_midreset_lat6", int'(btn_clean), 1);
      hold(1'b1, 3, "after_midreset_hold");

      check_int("scoreboard_drained", sb_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
